// File: rtl/cmd_frontend_pkg.sv
// +----------------------------------------------------------------------------+
// | cmd_frontend_pkg : shared command type, frontend state type, PROC_COUNT    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

package cmd_frontend_pkg;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] arg;
  } cmd_t;

  typedef enum logic [1:0] {
    FE_IDLE   = 2'd0,
    FE_ACTIVE = 2'd1,
    FE_DRAIN  = 2'd2
  } frontend_state_t;

endpackage

`default_nettype wire

// File: rtl/cmd_fifo.sv
// +----------------------------------------------------------------------------+
// | cmd_fifo : first-word-fall-through command storage with wrap-bit pointers  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmd_fifo #(
  parameter int  DEPTH = 8,
  parameter type cmd_t = logic [15:0]
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_wr_en,
  input  cmd_t                         i_wr_data,
  input  logic                         i_rd_en,
  output cmd_t                         o_rd_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int c_AW = $clog2(DEPTH);

  cmd_t            r_mem [DEPTH];
  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en && !o_full)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_rd_en && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !o_full) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;

endmodule

`default_nettype wire

// File: rtl/cmd_frontend.sv
// +----------------------------------------------------------------------------+
// | cmd_frontend : command FIFO front end with issue throttle and drain FSM    |
// | Optional statistics counters: CMD_FRONTEND_STATS_EN      Rev 1.0           |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmd_frontend
  import cmd_frontend_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int MAX_OUTSTANDING = `PROC_COUNT
) (
  input  logic                                 i_clk,
  input  logic                                 i_rstn,
  input  logic                                 i_push_valid,
  input  cmd_t                                 i_push_cmd,
  output logic                                 o_push_ready,
  input  logic                                 i_rd_queue,
  output cmd_t                                 o_cmd,
  output logic                                 o_queue_empty,
  input  logic                                 i_finished_task,
  input  logic                                 i_drain,
  output logic                                 o_drained,
  output logic [$clog2(DEPTH+1)-1:0]           o_count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding,
  output logic                                 o_idle
`ifdef CMD_FRONTEND_STATS_EN
  ,
  output logic [31:0]                          o_stat_pushed,
  output logic [31:0]                          o_stat_popped,
  output logic [31:0]                          o_stat_stall_cycles
`endif
);

  localparam int c_OW = $clog2(MAX_OUTSTANDING+1);

  frontend_state_t  r_state;
  frontend_state_t  w_state_next;
  logic             w_full;
  logic             w_fifo_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_fin;
  logic [c_OW-1:0]  r_outstanding;

  assign o_push_ready  = !w_full && (r_state != FE_DRAIN);
  assign w_push        = i_push_valid && o_push_ready;
  assign o_queue_empty = w_fifo_empty || (r_outstanding == c_OW'(MAX_OUTSTANDING));
  assign w_pop         = i_rd_queue && !o_queue_empty;
  assign w_fin         = i_finished_task && (r_outstanding != '0);
  assign o_idle        = w_fifo_empty && (r_outstanding == '0);
  assign o_outstanding = r_outstanding;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .cmd_t (cmd_t)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_wr_en   (w_push),
    .i_wr_data (i_push_cmd),
    .i_rd_en   (w_pop),
    .o_rd_data (o_cmd),
    .o_full    (w_full),
    .o_empty   (w_fifo_empty),
    .o_count   (o_count)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_outstanding <= '0;
    end else if (w_pop && !w_fin) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (w_fin && !w_pop) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= FE_IDLE;
    else         r_state <= w_state_next;
  end

  // A push landing in the same cycle keeps ACTIVE from falling back to IDLE.
  always_comb begin
    w_state_next = r_state;
    o_drained    = 1'b0;
    case (r_state)
      FE_IDLE: begin
        if (i_drain)     w_state_next = FE_DRAIN;
        else if (w_push) w_state_next = FE_ACTIVE;
      end
      FE_ACTIVE: begin
        if (i_drain)                 w_state_next = FE_DRAIN;
        else if (o_idle && !w_push)  w_state_next = FE_IDLE;
      end
      FE_DRAIN: begin
        if (o_idle) begin
          w_state_next = FE_IDLE;
          o_drained    = 1'b1;
        end
      end
      default: w_state_next = FE_IDLE;
    endcase
  end

`ifdef CMD_FRONTEND_STATS_EN
  logic [31:0] r_stat_pushed;
  logic [31:0] r_stat_popped;
  logic [31:0] r_stat_stall_cycles;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_stat_pushed       <= '0;
      r_stat_popped       <= '0;
      r_stat_stall_cycles <= '0;
    end else begin
      if (w_push && (r_stat_pushed != '1)) r_stat_pushed <= r_stat_pushed + 32'd1;
      if (w_pop && (r_stat_popped != '1))  r_stat_popped <= r_stat_popped + 32'd1;
      if (i_push_valid && !o_push_ready && (r_stat_stall_cycles != '1))
        r_stat_stall_cycles <= r_stat_stall_cycles + 32'd1;
    end
  end

  assign o_stat_pushed       = r_stat_pushed;
  assign o_stat_popped       = r_stat_popped;
  assign o_stat_stall_cycles = r_stat_stall_cycles;
`endif

endmodule

`default_nettype wire
